spi_display_arbiter: RTL and testbench
======================================

SPI_DISPLAY_ARBITER -- requirements
Module: spi_display_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: clk cycles allowed in BUSY+DONE per byte before abort.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 (message ROM sequencer) has a byte; held until req0_ack.
REQ-005 req0_data  input  8  requester 0 byte; stable while req0_valid high.
REQ-006 req0_last  input  1  requester 0 byte ends its message; stable while req0_valid high.
REQ-007 req0_ack  output  1  one-cycle pulse: requester 0 byte accepted.
REQ-008 req1_valid / req1_data[7:0] / req1_last / req1_ack: same as REQ-004..007 for requester 1 (keypad echo).
REQ-009 dataRdy  output  1  one-cycle strobe to the SPI display transmitter: data valid.
REQ-010 data  output  8  byte to transmitter; held from the SEND cycle until the next SEND.
REQ-011 transEna  input  1  transmitter ready; low while shifting, high when idle/done.
REQ-012 grant  output  2  one-hot owner of the transmitter (bit n = requester n); 00 when unowned.
REQ-013 timeout_err  output  1  sticky; set on any transmit timeout.

Function
REQ-014 States: IDLE, SEND, BUSY, DONE, HOLD; all outputs registered.
REQ-015 IDLE: no valid -> stay, grant=00; one valid -> win that requester; both valid -> win requester != last_served.
REQ-016 IDLE win: latch byte and last flag, set grant, go SEND; next cycle dataRdy=1, data=byte, reqN_ack=1 (same cycle).
REQ-017 SEND lasts exactly one cycle, then BUSY; transEna ignored during SEND.
REQ-018 BUSY: wait for transEna=0 (transmitter took byte), then DONE.
REQ-019 DONE: wait for transEna=1; then latched last=1 -> IDLE, grant=00, last_served=owner; last=0 -> HOLD.
REQ-020 HOLD: grant kept; owner valid -> latch byte, go SEND (REQ-016); other requester ignored (no message interleave).
REQ-021 HOLD has no timeout; owner is responsible for completing its message with last=1.
REQ-022 Timeout counter clears on entry to BUSY, increments each cycle in BUSY/DONE; reaching TIMEOUT -> timeout_err=1, grant=00, last_served=owner, go IDLE.
REQ-023 Counter width ceil(log2(TIMEOUT+1)); no wrap before TIMEOUT reached.
REQ-024 Minimum byte period: 4 cycles (IDLE/HOLD, SEND, BUSY, DONE) with immediate transEna response.
REQ-025 At most one reqN_ack per SEND; never an ack to the non-owner.
REQ-026 Valid dropping without ack: byte not sent, no error; owner in HOLD simply waits.
REQ-027 timeout_err clears only on rst.

Reset
REQ-028 rst=1 (any state, any time): state=IDLE, dataRdy=0, data=00, req0_ack=req1_ack=0, grant=00, timeout_err=0, counter=0, last_served=1 (requester 0 wins first tie).
REQ-029 Reset mid-transfer drops the byte and lock; no ack or dataRdy during or on the cycle after rst release.

Verification
REQ-030 Reset release, req0 sends 0x41 last=1, transEna low 3 cycles then high -> one dataRdy with data=0x41, req0_ack same cycle, grant 01 -> 00.
REQ-031 Both valid from IDLE after reset (0x11 last=1, 0x22 last=1) -> 0x11 first, then 0x22; next tie goes to requester 0.
REQ-032 req0 message 0x48,0x49,0x00-terminated as last=1 on 0x49 while req1 valid 0x35 throughout -> dataRdy sequence 0x48,0x49,0x35, grant stays 01 for both req0 bytes.
REQ-033 TIMEOUT=8, transEna stuck high after SEND -> timeout_err=1 exactly 8 cycles after BUSY entry, grant=00, IDLE; next request still served.
REQ-034 rst asserted in DONE with req1 owner -> all outputs reset immediately; after release req1 re-requests and byte resent with fresh ack.
REQ-035 transEna pulse high during SEND only -> ignored; DONE entered only after BUSY sees low.

Source files
------------

// File: rtl/spi_display_arbiter.sv
// Two-requester arbiter for a shared SPI display transmitter. A requester keeps
// ownership across a multi-byte message until it marks a byte as last.
module spi_display_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ack,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ack,
    output logic       dataRdy,
    output logic [7:0] data,
    input  logic       transEna,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        BUSY,
        DONE,
        HOLD
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last_flag, last_flag_n;
    logic          last_served, last_served_n;
    logic [7:0]    data_n;
    logic          data_rdy_n;
    logic          ack0_n, ack1_n;
    logic [1:0]    grant_n;
    logic          err_n;
    logic          win0, win1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_flag   <= 1'b0;
            last_served <= 1'b1;
            data        <= '0;
            dataRdy     <= 1'b0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            grant       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_flag   <= last_flag_n;
            last_served <= last_served_n;
            data        <= data_n;
            dataRdy     <= data_rdy_n;
            req0_ack    <= ack0_n;
            req1_ack    <= ack1_n;
            grant       <= grant_n;
            timeout_err <= err_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        last_flag_n   = last_flag;
        last_served_n = last_served;
        data_n        = data;
        data_rdy_n    = 1'b0;
        ack0_n        = 1'b0;
        ack1_n        = 1'b0;
        grant_n       = grant;
        err_n         = timeout_err;
        win0          = 1'b0;
        win1          = 1'b0;

        unique case (state)
            IDLE: begin
                grant_n = '0;
                // On a tie the requester not served most recently wins.
                if (req0_valid && (!req1_valid || last_served))
                    win0 = 1'b1;
                else if (req1_valid)
                    win1 = 1'b1;
            end
            HOLD: begin
                if (grant[0] && req0_valid)
                    win0 = 1'b1;
                else if (grant[1] && req1_valid)
                    win1 = 1'b1;
            end
            SEND: begin
                state_n = BUSY;
                cnt_n   = '0;
            end
            BUSY, DONE: begin
                if (cnt == CNT_LAST) begin
                    err_n         = 1'b1;
                    grant_n       = '0;
                    last_served_n = grant[1];
                    state_n       = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                    if (state == BUSY) begin
                        if (!transEna)
                            state_n = DONE;
                    end else if (transEna) begin
                        if (last_flag) begin
                            state_n       = IDLE;
                            grant_n       = '0;
                            last_served_n = grant[1];
                        end else begin
                            state_n = HOLD;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (win0) begin
            data_n      = req0_data;
            last_flag_n = req0_last;
            grant_n     = 2'b01;
            ack0_n      = 1'b1;
            data_rdy_n  = 1'b1;
            state_n     = SEND;
        end else if (win1) begin
            data_n      = req1_data;
            last_flag_n = req1_last;
            grant_n     = 2'b10;
            ack1_n      = 1'b1;
            data_rdy_n  = 1'b1;
            state_n     = SEND;
        end
    end

endmodule

// File: tb/tb_spi_display_arbiter.sv
// Directed bench for spi_display_arbiter: queued requesters, a simple
// transmitter model, and an event log of every dataRdy strobe.
module tb_spi_display_arbiter;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ack;
    logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ack;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00, data;
    logic       dataRdy, timeout_err, transEna;
    logic [1:0] grant;

    logic tx_manual  = 1'b0;
    logic tx_man_val = 1'b1;
    logic tx_model   = 1'b1;
    assign transEna = tx_manual ? tx_man_val : tx_model;

    spi_display_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ack(req1_ack),
        .dataRdy(dataRdy), .data(data), .transEna(transEna),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       a0;
        logic       a1;
        logic [1:0] g;
        int         c;
    } ev_t;

    logic [8:0] src0[$], src1[$];   // {last, data}, appended by the test
    int head0 = 0, head1 = 0;
    int drop1_req = 0, drop1_done = 0;
    int tx_n = 2, tx_k = 0;
    int stray = 0;
    ev_t evq[$];

    // Requesters, transmitter model and event log, all acting on the falling edge.
    always @(negedge clk) begin
        if (dataRdy)
            evq.push_back('{data, req0_ack, req1_ack, grant, cyc});
        if ((req0_ack && !(dataRdy && grant == 2'b01)) || (req1_ack && !(dataRdy && grant == 2'b10)))
            stray++;
        if (req0_ack && head0 < src0.size()) head0++;
        if (req1_ack && head1 < src1.size()) head1++;
        if (drop1_req != drop1_done) begin
            if (head1 < src1.size()) head1++;
            drop1_done++;
        end
        req0_valid = head0 < src0.size();
        req0_data  = req0_valid ? src0[head0][7:0] : 8'h00;
        req0_last  = req0_valid ? src0[head0][8] : 1'b0;
        req1_valid = head1 < src1.size();
        req1_data  = req1_valid ? src1[head1][7:0] : 8'h00;
        req1_last  = req1_valid ? src1[head1][8] : 1'b0;
        if (rst) begin
            tx_model = 1'b1;
            tx_k     = 0;
        end else if (dataRdy && tx_n > 0) begin
            tx_model = 1'b0;
            tx_k     = tx_n;
        end else if (tx_k > 0) begin
            tx_k--;
            if (tx_k == 0) tx_model = 1'b1;
        end
    end

    int passed = 0, total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_ev(input string tag, input int idx, input logic [7:0] d, input logic [1:0] g);
        if (idx < evq.size()) begin
            check({tag, "_data"}, evq[idx].d, d);
            check({tag, "_grant"}, evq[idx].g, g);
            check({tag, "_acks"}, {evq[idx].a1, evq[idx].a0}, g);
        end else begin
            check({tag, "_present"}, evq.size(), idx + 1);
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        @(posedge clk); #1;
        while ((req0_valid || req1_valid || grant != 2'b00 || !transEna) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_idle_wait"}, (n < limit), 1);
    endtask

    task automatic wait_rdy(input string tag, input int limit, output int c);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!dataRdy && n < limit);
        check({tag, "_rdy_wait"}, dataRdy, 1);
        c = cyc;
    endtask

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        int         tx;
        int         n;
        logic [7:0] e0d;
        logic [1:0] e0g;
        logic [7:0] e1d;
        logic [1:0] e1g;
    } vec_t;

    vec_t tbl[7];
    int base, c1, c2, r, n_bad, lim;

    initial begin
        // Single-byte rounds; tie winners follow the alternation from last_served.
        tbl[0] = '{1'b1, 8'h11, 1'b1, 8'h22, 2, 2, 8'h11, 2'b01, 8'h22, 2'b10};
        tbl[1] = '{1'b1, 8'h33, 1'b1, 8'h44, 3, 2, 8'h33, 2'b01, 8'h44, 2'b10};
        tbl[2] = '{1'b1, 8'h55, 1'b0, 8'h00, 2, 1, 8'h55, 2'b01, 8'h00, 2'b00};
        tbl[3] = '{1'b1, 8'h66, 1'b1, 8'h77, 4, 2, 8'h77, 2'b10, 8'h66, 2'b01};
        tbl[4] = '{1'b1, 8'h88, 1'b1, 8'h99, 2, 2, 8'h99, 2'b10, 8'h88, 2'b01};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 8'hAA, 3, 1, 8'hAA, 2'b10, 8'h00, 2'b00};
        tbl[6] = '{1'b1, 8'hBB, 1'b1, 8'hCC, 2, 2, 8'hBB, 2'b01, 8'hCC, 2'b10};

        // Reset values, with a request already pending.
        tx_n = 3;
        src0.push_back({1'b1, 8'h41});
        repeat (3) @(posedge clk);
        #1;
        check("rst_dataRdy", dataRdy, 0);
        check("rst_data", data, 8'h00);
        check("rst_acks", {req1_ack, req0_ack}, 2'b00);
        check("rst_grant", grant, 2'b00);
        check("rst_err", timeout_err, 0);

        // Single byte right after reset release.
        base = evq.size();
        rst = 1'b0;
        r = cyc;
        check("rel_dataRdy", dataRdy, 0);
        wait_rdy("b41", 10, c1);
        check("b41_latency", c1 - r, 1);
        check("b41_data", data, 8'h41);
        check("b41_acks", {req1_ack, req0_ack}, 2'b01);
        check("b41_grant", grant, 2'b01);
        wait_idle("b41", 20);
        check("b41_count", evq.size() - base, 1);
        check("b41_grant_end", grant, 2'b00);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            base = evq.size();
            tx_n = tbl[i].tx;
            if (tbl[i].v0) src0.push_back({1'b1, tbl[i].d0});
            if (tbl[i].v1) src1.push_back({1'b1, tbl[i].d1});
            wait_idle($sformatf("v%0d", i), 60);
            check($sformatf("v%0d_count", i), evq.size() - base, tbl[i].n);
            check_ev($sformatf("v%0d_e0", i), base, tbl[i].e0d, tbl[i].e0g);
            if (tbl[i].n == 2)
                check_ev($sformatf("v%0d_e1", i), base + 1, tbl[i].e1d, tbl[i].e1g);
        end

        // Message lock: req1 stays pending while req0 finishes its message.
        base = evq.size();
        tx_n = 2;
        src0.push_back({1'b0, 8'h48});
        src0.push_back({1'b1, 8'h49});
        src1.push_back({1'b1, 8'h35});
        wait_rdy("lock", 10, c1);
        n_bad = 0;
        lim = 0;
        do begin
            @(posedge clk); #1;
            if (grant != 2'b01) n_bad++;
            lim++;
        end while (!dataRdy && lim < 20);
        check("lock_grant_held", n_bad, 0);
        wait_idle("lock", 40);
        check("lock_count", evq.size() - base, 3);
        check_ev("lock_e0", base, 8'h48, 2'b01);
        check_ev("lock_e1", base + 1, 8'h49, 2'b01);
        check_ev("lock_e2", base + 2, 8'h35, 2'b10);

        // HOLD: owner idles past TIMEOUT, other requester raises and drops valid.
        base = evq.size();
        src0.push_back({1'b0, 8'hD0});
        wait_rdy("hold", 10, c1);
        repeat (5) @(posedge clk);
        #1;
        src1.push_back({1'b1, 8'hE1});
        repeat (12) @(posedge clk);
        #1;
        check("hold_grant", grant, 2'b01);
        check("hold_no_send", evq.size() - base, 1);
        check("hold_no_err", timeout_err, 0);
        drop1_req++;
        repeat (2) @(posedge clk);
        #1;
        check("hold_drop_valid", req1_valid, 0);
        src0.push_back({1'b1, 8'hD1});
        wait_idle("hold", 30);
        check("hold_count", evq.size() - base, 2);
        check_ev("hold_e0", base, 8'hD0, 2'b01);
        check_ev("hold_e1", base + 1, 8'hD1, 2'b01);
        check("hold_err_end", timeout_err, 0);

        // Transmitter never drops transEna: abort after TIMEOUT cycles.
        tx_n = 0;
        src0.push_back({1'b1, 8'hF0});
        wait_rdy("tmo", 10, c1);
        lim = 0;
        while (!timeout_err && lim < 30) begin
            @(posedge clk); #1;
            lim++;
        end
        c2 = cyc;
        check("tmo_err", timeout_err, 1);
        check("tmo_cycles", c2 - c1, TMO + 1);
        check("tmo_grant", grant, 2'b00);
        tx_n = 2;
        base = evq.size();
        src1.push_back({1'b1, 8'h3C});
        wait_idle("tmo_next", 30);
        check("tmo_next_count", evq.size() - base, 1);
        check_ev("tmo_next_e0", base, 8'h3C, 2'b10);
        check("tmo_sticky", timeout_err, 1);

        // transEna high only across the SEND edge must not count as completion.
        base = evq.size();
        tx_man_val = 1'b0;
        tx_manual  = 1'b1;
        src0.push_back({1'b1, 8'h5A});
        src0.push_back({1'b1, 8'h5B});
        wait_rdy("pulse", 10, c1);
        tx_man_val = 1'b1;
        @(posedge clk); #1;
        check("pulse_grant", grant, 2'b01);
        tx_man_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tx_man_val = 1'b1;
        wait_rdy("pulse2", 10, c2);
        tx_manual = 1'b0;
        check("pulse_period", c2 - c1, 6);
        wait_idle("pulse", 30);
        check_ev("pulse_e0", base, 8'h5A, 2'b01);
        check_ev("pulse_e1", base + 1, 8'h5B, 2'b01);

        // Reset while req1 owns the transmitter in DONE.
        base = evq.size();
        tx_man_val = 1'b1;
        tx_manual  = 1'b1;
        src1.push_back({1'b1, 8'h77});
        wait_rdy("rdone", 10, c1);
        tx_man_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rdone_grant_pre", grant, 2'b10);
        rst = 1'b1;
        #1;
        check("rdone_dataRdy", dataRdy, 0);
        check("rdone_data", data, 8'h00);
        check("rdone_acks", {req1_ack, req0_ack}, 2'b00);
        check("rdone_grant", grant, 2'b00);
        check("rdone_err", timeout_err, 0);
        src1.push_back({1'b1, 8'h77});
        repeat (2) @(posedge clk);
        #1;
        tx_man_val = 1'b1;
        tx_manual  = 1'b0;
        rst = 1'b0;
        r = cyc;
        check("rdone_rel_rdy", {dataRdy, req1_ack, req0_ack}, 3'b000);
        wait_rdy("rdone2", 10, c2);
        check("rdone_latency", c2 - r, 1);
        check("rdone2_acks", {req1_ack, req0_ack}, 2'b10);
        wait_idle("rdone", 30);
        check("rdone_count", evq.size() - base, 2);
        check_ev("rdone_e1", base + 1, 8'h77, 2'b10);

        check("stray_acks", stray, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
